guess_entry: RTL
================

Name: guess_entry

Overview:
- Player-side producer of guess letters for the Wordle game FSM.
- Nexys4 buttons scroll an ASCII cursor letter A-Z, commit letters into a 5-slot guess buffer, and support backspace.
- On submit, the buffer is streamed to the game FSM one letter per accepted transfer over a valid/ready handshake.
- Sits between the button debouncers and the game state machine; also drives the display with buffer and cursor contents.

Parameters:
- WORD_LEN, 5, letters per guess; buffer width is 8*WORD_LEN.
- FIRST_CHAR, 8'h41, ASCII 'A', lowest cursor value.
- LAST_CHAR, 8'h5A, ASCII 'Z', highest cursor value.

Ports:
- Clk  input  1  system clock
- reset  input  1  asynchronous, active-high
- enable  input  1  high while the game FSM is in a guess state; low forces IDLE
- BtnU_p  input  1  one-cycle debounced pulse: cursor next letter
- BtnD_p  input  1  one-cycle debounced pulse: cursor previous letter
- BtnC_p  input  1  one-cycle debounced pulse: commit letter, or submit when buffer full
- BtnL_p  input  1  one-cycle debounced pulse: backspace
- out_ready  input  1  consumer accepts out_letter this cycle
- out_valid  output  1  out_letter is valid
- out_letter  output  8  ASCII letter being sent
- out_last  output  1  high with the final (5th) letter
- word_sent  output  1  one-cycle pulse after the final letter is accepted
- cursor_letter  output  8  current scroll letter, for display
- guess_buf  output  40  slot0 in [39:32] through slot4 in [7:0]; empty slot = 8'h00
- count  output  3  committed letters, 0..5
- q_Idle, q_Edit, q_Send  output  1 each  one-hot state

Behaviour:
- Reset:
  - state IDLE.
  - cursor_letter = 8'h41.
  - guess_buf = 0; count = 0; internal send index idx = 0.
  - out_valid, out_last, word_sent = 0.
- All outputs are registered. The effect of an input is visible the cycle after it is sampled.
- IDLE:
  - Buttons are ignored.
  - When enable = 1, go to EDIT.
  - On entry, guess_buf and count are cleared and cursor is set to 'A'.
- EDIT: at most one action per cycle, chosen by priority C > L > U/D.
  - BtnC_p with count < 5: slot[count] <= cursor; count++; cursor <= 'A'.
  - BtnC_p with count == 5: go to SEND with idx = 0. Buffer is unchanged.
  - BtnL_p with count > 0: count--; slot[count-1] <= 8'h00; cursor is unchanged.
  - BtnL_p with count == 0: no effect.
  - BtnU_p alone: cursor++; 'Z' wraps to 'A'.
  - BtnD_p alone: cursor--; 'A' wraps to 'Z'.
  - BtnU_p and BtnD_p together, with no C or L: no change.
- SEND:
  - out_valid = 1 and out_letter = slot[idx].
  - out_last = (idx == 4).
  - Transfer occurs on out_valid & out_ready. On transfer, idx++.
  - On the transfer with idx == 4:
    - next cycle: state EDIT, guess_buf cleared, count = 0, cursor = 'A';
    - out_valid = 0 and word_sent = 1 for one cycle.
  - out_letter is held stable while out_ready = 0.
  - Buttons are ignored in SEND.
- enable = 0 in any state:
  - next state IDLE.
  - out_valid, out_last = 0.
  - Buffer is cleared; a SEND in progress aborts and no word_sent pulse is issued.
  - enable has priority over all buttons.
- Minimum send time is 5 cycles with out_ready held high; there are no bubbles between letters.
- Reset asserted mid-SEND returns to the reset values immediately (asynchronous).
- idx never exceeds 4. count never exceeds 5; a commit at count == 5 is always treated as submit.

Test Plan:
- Reset, then enable = 1, then BtnU_p x3 -> cursor_letter = 8'h44 ('D'), count = 0, q_Edit = 1.
- From 'A', BtnD_p -> 'Z' (8'h5A); then BtnU_p -> 'A'. BtnU_p and BtnD_p in the same cycle -> no change.
- Commit R,E,N,E,W, then BtnC_p with out_ready = 1 -> out_letter sequence 52,45,4E,45,57 on 5 consecutive cycles; out_last only on 57; word_sent pulses next cycle; count = 0.
- Commit 3 letters, BtnL_p -> count = 2, guess_buf[23:16] = 0. BtnC_p and BtnL_p in the same cycle -> commit only, count = 3.
- During SEND, hold out_ready = 0 for 4 cycles after the 2nd letter -> out_letter stays on the 3rd letter with out_valid = 1; resume -> remaining letters delivered in order, no duplication.
- Drop enable after 2 of 5 letters are sent -> next cycle q_Idle = 1, out_valid = 0, guess_buf = 0, no word_sent. Assert reset mid-EDIT -> all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/guess_entry_if.sv
`default_nettype none
// ============================================================================
// Module   : guess_entry_if
// Purpose  : Valid/ready letter stream from the guess entry block to the game
//            state machine.
// Signals  : out_valid  - producer has a letter on out_letter
//            out_ready  - consumer accepts out_letter this cycle
//            out_letter - ASCII letter being transferred
//            out_last   - marks the final letter of the word
// Revision : 1.0 - initial release
// ============================================================================
interface guess_entry_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_letter;
  logic       out_last;

  modport master (
    output out_valid,
    output out_letter,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_letter,
    input  out_last,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/guess_entry.sv
`default_nettype none
// ============================================================================
// Module   : guess_entry
// Purpose  : Player-side guess entry for the Wordle game. Buttons scroll a
//            cursor letter, commit letters into a WORD_LEN-slot buffer, and
//            backspace. A commit on a full buffer submits the word, which is
//            streamed one letter per accepted transfer on out_if.
// Ports    : Clk, reset (async, active-high)
//            enable        - high while the game is waiting for a guess
//            BtnU/D/C/L_p  - one-cycle debounced button pulses
//            out_if        - valid/ready letter stream (master side)
//            word_sent     - one-cycle pulse after the last letter is taken
//            cursor_letter - current scroll letter
//            guess_buf     - slot0 in the top byte, empty slot = 8'h00
//            count         - committed letters
//            q_Idle/q_Edit/q_Send - one-hot state
// Revision : 1.0 - initial release
// ============================================================================
module guess_entry #(
  parameter int         WORD_LEN   = 5,
  parameter logic [7:0] FIRST_CHAR = 8'h41,
  parameter logic [7:0] LAST_CHAR  = 8'h5A
) (
  input  wire logic                  Clk,
  input  wire logic                  reset,
  input  wire logic                  enable,
  input  wire logic                  BtnU_p,
  input  wire logic                  BtnD_p,
  input  wire logic                  BtnC_p,
  input  wire logic                  BtnL_p,
  guess_entry_if.master              out_if,
  output logic                       word_sent,
  output logic [7:0]                 cursor_letter,
  output logic [8*WORD_LEN-1:0]      guess_buf,
  output logic [2:0]                 count,
  output logic                       q_Idle,
  output logic                       q_Edit,
  output logic                       q_Send
);

  localparam logic [2:0] c_FULL     = 3'(WORD_LEN);
  localparam logic [2:0] c_LAST_IDX = 3'(WORD_LEN - 1);

  // One-hot encoding so the q_* outputs are plain register bits.
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_EDIT = 3'b010,
    S_SEND = 3'b100
  } state_t;

  state_t                r_state;
  logic [7:0]            r_cursor;
  logic [8*WORD_LEN-1:0] r_buf;
  logic [2:0]            r_count;
  logic [2:0]            r_idx;
  logic                  r_valid;
  logic                  r_last;
  logic [7:0]            r_letter;
  logic                  r_ws;

  logic [7:0]            w_slot [WORD_LEN];
  logic [2:0]            w_idx_nxt;
  logic [2:0]            w_count_dec;

  generate
    for (genvar g = 0; g < WORD_LEN; g++) begin : g_slot
      assign w_slot[g] = r_buf[8*(WORD_LEN-1-g) +: 8];
    end
  endgenerate

  assign w_idx_nxt   = r_idx + 3'd1;
  assign w_count_dec = r_count - 3'd1;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cursor <= FIRST_CHAR;
      r_buf    <= '0;
      r_count  <= 3'd0;
      r_idx    <= 3'd0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_letter <= 8'h00;
      r_ws     <= 1'b0;
    end else if (!enable) begin
      // Leaving the guess phase aborts everything, including a send.
      r_state  <= S_IDLE;
      r_cursor <= FIRST_CHAR;
      r_buf    <= '0;
      r_count  <= 3'd0;
      r_idx    <= 3'd0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_ws     <= 1'b0;
    end else begin
      r_ws <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state  <= S_EDIT;
          r_cursor <= FIRST_CHAR;
          r_buf    <= '0;
          r_count  <= 3'd0;
          r_idx    <= 3'd0;
        end

        S_EDIT: begin
          if (BtnC_p) begin
            if (r_count == c_FULL) begin
              // Submit: present slot0 immediately so there is no bubble.
              r_state  <= S_SEND;
              r_idx    <= 3'd0;
              r_valid  <= 1'b1;
              r_letter <= w_slot[0];
              r_last   <= (c_LAST_IDX == 3'd0);
            end else begin
              for (int i = 0; i < WORD_LEN; i++) begin
                if (r_count == 3'(i))
                  r_buf[8*(WORD_LEN-1-i) +: 8] <= r_cursor;
              end
              r_count  <= r_count + 3'd1;
              r_cursor <= FIRST_CHAR;
            end
          end else if (BtnL_p) begin
            if (r_count != 3'd0) begin
              for (int i = 0; i < WORD_LEN; i++) begin
                if (w_count_dec == 3'(i))
                  r_buf[8*(WORD_LEN-1-i) +: 8] <= 8'h00;
              end
              r_count <= w_count_dec;
            end
          end else if (BtnU_p && !BtnD_p) begin
            r_cursor <= (r_cursor == LAST_CHAR) ? FIRST_CHAR : r_cursor + 8'd1;
          end else if (BtnD_p && !BtnU_p) begin
            r_cursor <= (r_cursor == FIRST_CHAR) ? LAST_CHAR : r_cursor - 8'd1;
          end
        end

        S_SEND: begin
          if (r_valid && out_if.out_ready) begin
            if (r_idx == c_LAST_IDX) begin
              r_state  <= S_EDIT;
              r_valid  <= 1'b0;
              r_last   <= 1'b0;
              r_ws     <= 1'b1;
              r_buf    <= '0;
              r_count  <= 3'd0;
              r_idx    <= 3'd0;
              r_cursor <= FIRST_CHAR;
            end else begin
              // Preload the next letter so transfers are back to back.
              r_idx    <= w_idx_nxt;
              r_letter <= w_slot[w_idx_nxt];
              r_last   <= (w_idx_nxt == c_LAST_IDX);
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_if.out_valid  = r_valid;
  assign out_if.out_letter = r_letter;
  assign out_if.out_last   = r_last;
  assign word_sent         = r_ws;
  assign cursor_letter     = r_cursor;
  assign guess_buf         = r_buf;
  assign count             = r_count;
  assign q_Idle            = r_state[0];
  assign q_Edit            = r_state[1];
  assign q_Send            = r_state[2];

endmodule
`default_nettype wire
